fetch_queue_unit: RTL and testbench

- Instruction-fetch stage that sits directly around the program counter register.
- Upstream role: computes the PC's next address every cycle (sequential +4, hold on stall, redirect on branch/jump).
- Downstream role: captures the instruction word returned by the synchronous instruction memory for the current PC.
- Buffers fetched (pc, instr) pairs in a small FIFO and presents them to decode over a valid/ready handshake.

---
 rtl/fetch_queue_unit.sv | 120 ++++++++++++
 tb/tb_fetch_queue_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_unit.sv
// Instruction fetch around the PC: next-address selection, one-cycle imem capture and a
// small (pc, instr) queue toward decode. Define FETCH_PERF_CNT_EN to add stall/flush counters.
module fetch_queue_unit #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  curr_addr,
  output logic [ADDR_W-1:0]  next_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        flush_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [ADDR_W:0] LastSeq   = (ADDR_W + 1)'('h7C);
  localparam logic [ADDR_W:0] AddrLimit = (ADDR_W + 1)'('h80);

  typedef enum logic [1:0] {CntEmpty, CntPartial, CntFull} cnt_state_e;

  cnt_state_e         cnt_state;
  logic [CntW-1:0]    count;
  logic [CntW-1:0]    count_d;
  logic [PtrW-1:0]    rd_ptr;
  logic [PtrW-1:0]    wr_ptr;
  logic               inflight;
  logic [ADDR_W-1:0]  inflight_pc;
  logic [ADDR_W-1:0]  mem_pc    [DEPTH];
  logic [INSTR_W-1:0] mem_instr [DEPTH];

  logic               pop;
  logic               issue;
  logic [CntW:0]      occ;
  logic [ADDR_W:0]    seq_sum;
  logic [ADDR_W-1:0]  seq_addr;
  logic [ADDR_W-1:0]  redir_addr;

  assign id_valid = (cnt_state != CntEmpty);
  assign id_instr = id_valid ? mem_instr[rd_ptr] : '0;
  assign id_pc    = id_valid ? mem_pc[rd_ptr] : '0;

  always_comb begin
    pop      = id_valid & id_ready;
    // Slots already promised: queued entries plus the fetch whose data arrives this cycle.
    occ      = (CntW + 1)'(count) + (CntW + 1)'(inflight) - (CntW + 1)'(pop);
    issue    = !rst && !redirect_valid && (occ < (CntW + 1)'(DEPTH));
    count_d  = count + CntW'(inflight) - CntW'(pop);
    seq_sum  = {1'b0, curr_addr} + (ADDR_W + 1)'(4);
    seq_addr = (seq_sum <= LastSeq) ? seq_sum[ADDR_W-1:0] : '0;
    redir_addr = ({1'b0, redirect_target} >= AddrLimit) ? '0
                                                        : {redirect_target[ADDR_W-1:2], 2'b00};
    if (rst) begin
      next_addr = '0;
    end else if (redirect_valid) begin
      next_addr = redir_addr;
    end else if (issue) begin
      next_addr = seq_addr;
    end else begin
      next_addr = curr_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      // Flush drops the in-flight word and any same-cycle pop.
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      inflight  <= 1'b0;
      cnt_state <= CntEmpty;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= curr_addr;
      end
      if (inflight) begin
        mem_pc[wr_ptr]    <= inflight_pc;
        mem_instr[wr_ptr] <= imem_rdata;
        wr_ptr            <= wr_ptr + PtrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      count <= count_d;
      if (count_d == '0) begin
        cnt_state <= CntEmpty;
      end else if (count_d == CntW'(DEPTH)) begin
        cnt_state <= CntFull;
      end else begin
        cnt_state <= CntPartial;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (redirect_valid) begin
      if (flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end else if (!issue) begin
      if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: PC register and synchronous ROM modelled here; delivered
// (pc, instr) pairs are checked against the expected address stream via a scoreboard queue.
module tb_fetch_queue_unit;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_target = 8'h00;
  logic        id_ready = 1'b0;
  logic [7:0]  pc = 8'h00;
  logic [31:0] imem_rdata = 32'h0;
  logic [7:0]  next_addr;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [7:0]  id_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] gen_pc = 8'h00;

  fetch_queue_unit #(.DEPTH(DEPTH), .INSTR_W(32), .ADDR_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .curr_addr       (pc),
    .next_addr       (next_addr),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .id_instr        (id_instr),
    .id_pc           (id_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [7:0] a);
    return 32'hA500_0000 | {24'h0, a};
  endfunction

  function automatic logic [7:0] clamp(input logic [7:0] t);
    return (t >= 8'h80) ? 8'h00 : {t[7:2], 2'b00};
  endfunction

  // Environment: PC register and one-cycle-latency instruction ROM.
  always @(posedge clk) begin
    pc         <= next_addr;
    imem_rdata <= rom(pc);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic restart(input logic [7:0] base);
    exp_q.delete();
    gen_pc = base;
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(gen_pc);
      gen_pc = (gen_pc == 8'h7C) ? 8'h00 : gen_pc + 8'd4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input bit r, input bit rdy, input bit rv, input logic [7:0] tgt);
    rst             = r;
    id_ready        = rdy;
    redirect_valid  = rv;
    redirect_target = tgt;
    if (r) restart(8'h00);
    else if (rv) restart(clamp(tgt));
    refill();
  endtask

  task automatic drive(input bit r, input bit rdy, input bit rv, input logic [7:0] tgt,
                       input int n);
    for (int i = 0; i < n; i++) begin
      step();
      apply(r, rdy, rv, tgt);
    end
  endtask

  // Monitor: samples mid-cycle, pops the scoreboard on every accepted head.
  int          age = 100;
  int          hold_run = 0;
  int          gap = 0;
  bit          prev_hold = 1'b0;
  bit          from_rst = 1'b0;
  logic [7:0]  prev_pc;
  logic [31:0] prev_instr;
  logic [7:0]  e;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_next_addr", 64'(next_addr), 64'h0);
      age = 0; hold_run = 0; gap = 0; prev_hold = 1'b0; from_rst = 1'b1;
    end else if (redirect_valid) begin
      check("redirect_next_addr", 64'(next_addr), 64'(clamp(redirect_target)));
      age = 0; hold_run = 0; gap = 0; prev_hold = 1'b0; from_rst = 1'b0;
    end else begin
      age++;
      if (age <= 2) check("flush_gap_valid", 64'(id_valid), 64'h0);
      if (age == 3) check("flush_latency_valid", 64'(id_valid), 64'h1);
`ifdef FETCH_PERF_CNT_EN
      if (age == 1 && from_rst) check("perf_cnt_cleared", {32'h0, stall_cnt, flush_cnt}, 64'h0);
`endif
      if (!id_valid) check("empty_head_zero", {24'h0, id_pc, id_instr}, 64'h0);
      if (prev_hold) check("hold_stable", {24'h0, id_pc, id_instr}, {24'h0, prev_pc, prev_instr});
      if (id_valid && !id_ready) hold_run++;
      else hold_run = 0;
      if (hold_run >= DEPTH) check("stall_holds_pc", 64'(next_addr), 64'(pc));
      if (age > 3) begin
        if (!id_valid) gap++;
        else gap = 0;
        if (gap > 2) check("valid_gap", 64'(gap), 64'h2);
      end
      if (id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_delivery", 64'(id_pc), 64'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check("deliver_pc", 64'(id_pc), 64'(e));
          check("deliver_instr", 64'(id_instr), 64'(rom(e)));
        end
      end
      prev_hold  = id_valid && !id_ready;
      prev_pc    = id_pc;
      prev_instr = id_instr;
    end
  end

  int n;

  initial begin
    refill();
    // Streaming from reset, long enough to wrap 0x7C -> 0x00.
    drive(1'b1, 1'b1, 1'b0, 8'h00, 2);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 50);
    // Backpressure then release.
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 6);
    // Redirect when the PC reaches 0x10.
    n = 0;
    step();
    while (pc != 8'h10 && n < 64) begin
      apply(1'b0, 1'b1, 1'b0, 8'h00);
      step();
      n++;
    end
    check("reach_pc_10", 64'(pc), 64'h10);
    apply(1'b0, 1'b1, 1'b1, 8'h40);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 10);
    // Full queue, pop and redirect together.
    drive(1'b0, 1'b0, 1'b0, 8'h00, 5);
    drive(1'b0, 1'b1, 1'b1, 8'h23, 1);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 8);
    // Reset mid-operation with a loaded queue.
    drive(1'b0, 1'b0, 1'b0, 8'h00, 2);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 10);
    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      step();
      apply(($urandom % 100) == 0, ($urandom % 3) != 0, ($urandom % 20) == 0,
            8'($urandom_range(0, 255)));
    end
    drive(1'b0, 1'b1, 1'b0, 8'h00, 5);
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
